// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the control decoder and the instruction encoder.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FMT_R      = 2'b00,
    FMT_LOAD   = 2'b01,
    FMT_STORE  = 2'b10,
    FMT_BRANCH = 2'b11
  } fmt_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder. The master side is the
// request producer and word consumer; the slave side is the encoder itself.
interface instr_encoder_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [12:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] out_addr;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, out_addr, count
  );

  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr, out_addr, count
  );

endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO with occupancy count. Push is refused when full and pop
// when empty; flush empties it and blocks both operations that cycle.
// The read port shows zero while empty so the output is clean after reset.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // storage write; contents need no reset since reads are masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally at DEPTH; count tracks push/pop balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field-level requests into RV32I words
// (R, LOAD, STORE, BRANCH), queues them and streams them out with a byte
// address that advances by 4 per accepted word.
// Optional macro INSTR_ENC_CHECK_EN adds a sticky err output flagging
// misaligned branch offsets and out-of-range load/store offsets.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  instr_encoder_if.slave     bus
`ifdef INSTR_ENC_CHECK_EN
  ,
  output logic               err
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]       enc_word;
  logic              accept;
  logic              out_hs;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W-1:0] addr;

  // in_ready comes only from registered occupancy, so no comb path exists
  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign bus.count     = fifo_count;
  assign bus.out_addr  = addr;
  assign accept        = bus.in_valid && !fifo_full && !flush;
  assign out_hs        = !fifo_empty && bus.out_ready && !flush;

  // field packing per opcode class; fields unused by a format are ignored
  always_comb begin
    enc_word = '0;
    case (bus.fmt)
      FMT_R:
        enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
      FMT_LOAD:
        enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_LOAD};
      FMT_STORE:
        enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                    bus.imm[4:0], OP_STORE};
      FMT_BRANCH:
        enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                    bus.imm[4:1], bus.imm[11], OP_BRANCH};
      default:
        enc_word = '0;
    endcase
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (accept),
    .pop   (out_hs),
    .wdata (enc_word),
    .rdata (bus.instr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // byte address of the head word; wraps modulo 2^ADDR_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      addr <= BASE_ADDR;
    else if (flush)  addr <= BASE_ADDR;
    else if (out_hs) addr <= addr + ADDR_W'(4);
  end

`ifdef INSTR_ENC_CHECK_EN
  logic bad_req;

  // offset legality for the requested format
  always_comb begin
    bad_req = 1'b0;
    case (bus.fmt)
      FMT_BRANCH:          bad_req = bus.imm[0];
      FMT_LOAD, FMT_STORE: bad_req = bus.imm[12] ^ bus.imm[11];
      default:             bad_req = 1'b0;
    endcase
  end

  // sticky error; the offending word is still queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err <= 1'b0;
    else if (flush)              err <= 1'b0;
    else if (accept && bad_req)  err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected word/address
// pairs, an independent monitor pops and compares on each output handshake.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
`ifdef INSTR_ENC_CHECK_EN
  logic err;
`endif

  always #5 clk = ~clk;

  instr_encoder_if #(.DEPTH(4), .ADDR_W(32)) bus ();

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef INSTR_ENC_CHECK_EN
    ,
    .err   (err)
`endif
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_addr;
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // monitor: compare every accepted output word against the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && flush === 1'b0 && bus.out_valid === 1'b1 &&
        bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got word 0x%08h, scoreboard empty",
                 bus.instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_instr", bus.instr, e.word);
        check("mon_addr", bus.out_addr, e.addr);
      end
    end
  end

  task automatic send(input logic [1:0] f, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] imm, input logic [31:0] exp);
    bit ok = 0;
    bus.fmt = f; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
    bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        sb.push_back('{word: exp, addr: exp_addr});
        exp_addr = exp_addr + 32'd4;
        ok = 1;
        break;
      end
    end
    check("send_accepted", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.out_valid === 1'b0) begin
        done = 1;
        break;
      end
    end
    check("drain_done", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    exp_addr = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; exp_addr = 32'h0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.fmt = 2'b00;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.funct3 = '0;
    bus.funct7 = '0; bus.imm = '0;
    #12;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_out_addr", bus.out_addr, 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef INSTR_ENC_CHECK_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1-3: one of each format, streamed back to back
    send(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 32'h002081B3);
    check("lat_out_valid", 32'(bus.out_valid), 32'd1);
    check("lat_instr", bus.instr, 32'h002081B3);
    check("lat_out_addr", bus.out_addr, 32'h0);
    send(2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8, 32'h00812283);
    send(2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'd12, 32'h00512623);
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8, 32'hFE208CE3);
    wait_drain();
    check("pre_flush_addr", bus.out_addr, 32'h10);
    do_flush();
    check("flush_addr", bus.out_addr, 32'h0);

    // 4: fill with consumer stalled, then drain in order
    bus.out_ready = 1'b0;
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 32'h000000B3);
    send(2'b00, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 32'h00000133);
    send(2'b00, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 32'h000001B3);
    send(2'b00, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 32'h00000233);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_count", 32'(bus.count), 32'd4);
    check("stall_head_instr", bus.instr, 32'h000000B3);
    check("stall_head_addr", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    send(2'b00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 32'h000002B3);
    wait_drain();

    // 5a: flush wins over a concurrent request
    do_flush();
    bus.out_ready = 1'b0;
    send(2'b01, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 13'd4, 32'h00408083);
    send(2'b01, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 13'd8, 32'h00808103);
    send(2'b01, 5'd3, 5'd1, 5'd0, 3'd0, 7'd0, 13'd12, 32'h00C08183);
    check("pre_flush_count", 32'(bus.count), 32'd3);
    bus.fmt = 2'b00; bus.rd = 5'd7; bus.in_valid = 1'b1;
    do_flush();
    bus.in_valid = 1'b0;
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_out_addr", bus.out_addr, 32'h0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    check("flush_not_captured", 32'(bus.count), 32'd0);

    // 5b: asynchronous reset in the middle of a drain
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 32'h000000B3);
    send(2'b00, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 32'h00000133);
    send(2'b00, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 32'h000001B3);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_drain_addr", bus.out_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_instr", bus.instr, 32'h0);
    check("arst_out_addr", bus.out_addr, 32'h0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1; exp_addr = 32'h0;
    @(posedge clk); #1;

`ifdef INSTR_ENC_CHECK_EN
    // 6: sticky offset checks
    check("err_clear", 32'(err), 32'd0);
    send(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0005, 32'h00000263);
    check("err_branch_misalign", 32'(err), 32'd1);
    send(2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8, 32'h00812283);
    check("err_sticky", 32'(err), 32'd1);
    wait_drain();
    do_flush();
    check("err_flush_clear", 32'(err), 32'd0);
    send(2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'd12, 32'h00512623);
    check("err_legal_store", 32'(err), 32'd0);
    send(2'b01, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0800, 32'h80000003);
    check("err_load_range", 32'(err), 32'd1);
    wait_drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the main control decoder.
- Packs field-level instruction requests into 32-bit RV32I words for the four opcode classes the decoder recognises: R-type 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
- Buffers the encoded words in a small FIFO and streams them out with an instruction-memory byte address.
- Sits between a testbench or boot sequencer and the instruction memory write port.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 32, width of the output byte address.
- BASE_ADDR, 0, address of the first word after reset or flush.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO and address
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- fmt  in  2  00 R, 01 LOAD, 10 STORE, 11 BRANCH
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3
- funct7  in  7  R-type only
- imm  in  13  signed; LOAD/STORE use imm[11:0], BRANCH uses imm[12:1]
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- instr  out  32  encoded word at FIFO head
- out_addr  out  ADDR_W  byte address of instr
- count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; count=0; out_valid=0; instr=0.
  - out_addr=BASE_ADDR; in_ready=1.
  - Reset mid-stream discards all buffered words.
- Encoding is combinational at the input; the result is written into the FIFO tail on input handshake.
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}
  - LOAD: {imm[11:0], rs1, funct3, rd, 0000011}
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}
  - Unused fields for a format are ignored.
- Latency: a request accepted in cycle N makes out_valid high in cycle N+1 if the FIFO was empty. There is no combinational input-to-output path.
- in_ready = (count != DEPTH), taken from registered state only.
  - When full, no push occurs even if a pop happens in the same cycle.
- out_valid = (count != 0); instr shows the head entry and holds stable while out_valid && !out_ready.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, pointers both advance.
- Pointers are log2(DEPTH) bits and wrap naturally.
- out_addr increments by 4 on each output handshake and wraps modulo 2^ADDR_W.
- flush has priority over push and pop in the same cycle: FIFO empties, out_addr returns to BASE_ADDR, and no handshake takes effect that cycle.
- Output handshake is AXI-stream style: the producer must not drop out_valid before it is accepted.

Optional Feature:
- Macro INSTR_ENC_CHECK_EN.
- When defined, add output err (1 bit, reset 0). It is sticky and cleared only by reset or flush. It is set on an accepted request when either:
  - fmt=BRANCH and imm[0]=1 (misaligned target), or
  - fmt=LOAD or STORE and imm[12] != imm[11] (offset out of 12-bit range).
- The word is still encoded and pushed.
- When not defined, the err port does not exist and no checks are made.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OP_R=7'b0110011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011. The control decoder uses the same constants.
  - fmt encoding constants FMT_R, FMT_LOAD, FMT_STORE, FMT_BRANCH.
- One sub-module: sync_fifo (parameterised WIDTH/DEPTH, with count).
- Encoding mux and address counter live in instr_encoder.

Test Plan:
1. Reset, then R rd=3 rs1=1 rs2=2 funct3=0 funct7=0 with out_ready=1 -> next cycle out_valid=1, instr=0x002081B3, out_addr=0x0; following word appears at 0x4.
2. LOAD rd=5 rs1=2 funct3=2 imm=8 -> 0x00812283. STORE rs2=5 rs1=2 funct3=2 imm=12 -> 0x00512623.
3. BRANCH rs1=1 rs2=2 funct3=0 imm=-8 (13'h1FF8) -> 0xFE208CE3.
4. out_ready=0, push 5 requests with DEPTH=4 -> in_ready=0 after the 4th push, count=4. Assert out_ready -> words drain in order at addresses 0x0, 0x4, 0x8, 0xC, then the 5th word.
5. Flush with count=3 and in_valid=1 in the same cycle -> count=0, out_valid=0, out_addr=BASE_ADDR, request not captured. Assert rst_n low mid-drain -> all outputs return to reset values asynchronously.
6. With INSTR_ENC_CHECK_EN, BRANCH imm=13'h0005 -> err=1 and stays 1 through later legal requests until flush.
